// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to hold the grant on one requester until its req_last byte completes.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int BUSY_TIMEOUT = 4095,
   localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
   localparam int CW = BUSY_TIMEOUT > 0 ? $clog2(BUSY_TIMEOUT + 1) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [GW-1:0]        grant_id,
   output logic                 active,
   output logic                 timeout_err
);
   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;
   state_t state;
   logic [GW-1:0] ptr, sel, nxt_id;
   logic found;
   logic [CW-1:0] cnt;
   logic [NUM_REQ-1:0] vmask;
`ifdef UART_ARB_LOCK_EN
   logic locked;
   assign vmask = locked ? req_valid & (NUM_REQ'(1) << grant_id) : req_valid;
`else
   logic unused_last;
   assign unused_last = ^req_last;
   assign vmask = req_valid;
`endif
   assign nxt_id = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
   assign active = state != IDLE;
   // lowest valid index at or above ptr wins, otherwise lowest valid overall (wrap)
   always_comb begin
      sel = '0;
      found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (vmask[i]) begin
         sel = GW'(i);
         found = 1'b1;
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) if (vmask[i] && GW'(i) >= ptr) sel = GW'(i);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         req_ready <= '0;
         tx_start <= 1'b0;
         tx_data <= '0;
         grant_id <= '0;
         timeout_err <= 1'b0;
         ptr <= '0;
         cnt <= '0;
`ifdef UART_ARB_LOCK_EN
         locked <= 1'b0;
`endif
      end else begin
         req_ready <= '0;
         tx_start <= 1'b0;
         case (state)
            IDLE: if (found && !tx_busy) begin
               tx_data <= req_data[{sel, 3'b000} +: 8];
               grant_id <= sel;
               req_ready <= NUM_REQ'(1) << sel;
`ifdef UART_ARB_LOCK_EN
               locked <= !req_last[sel];
`endif
               state <= LOAD;
            end
            LOAD: state <= START;
            START: begin
               tx_start <= 1'b1;
               cnt <= '0;
               state <= WAIT_HI;
            end
            WAIT_HI: if (tx_busy) state <= WAIT_LO;
            else if (cnt == CW'(BUSY_TIMEOUT)) begin
               timeout_err <= 1'b1;
               ptr <= nxt_id;
`ifdef UART_ARB_LOCK_EN
               locked <= 1'b0;
`endif
               state <= IDLE;
            end else cnt <= cnt + CW'(1);
            WAIT_LO: if (!tx_busy) begin
`ifdef UART_ARB_LOCK_EN
               ptr <= locked ? grant_id : nxt_id;
`else
               ptr <= nxt_id;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus scoreboarded sequences for uart_tx_arbiter (NUM_REQ=2, BUSY_TIMEOUT=15).
module tb_uart_tx_arbiter;
   localparam int N = 2;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [8*N-1:0] req_data = '0;
   logic tx_start, tx_busy, grant_id, active, timeout_err;
   logic [7:0] tx_data;
   int checks = 0, errors = 0;
   typedef struct {logic [7:0] data; logic gid;} exp_t;
   exp_t exp_q[$];
   typedef struct {logic r; logic [1:0] v; logic [7:0] d; logic [1:0] rdy; logic st; logic act; logic [7:0] td;} vec_t;
   vec_t vecs[11];
   logic busy_q = 1'b0, force_busy = 1'b0, busy_en = 1'b1;
   int bcnt = 0, busy_len = 3;

   uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant_id(grant_id), .active(active), .timeout_err(timeout_err));

   always #5 clk = ~clk;
   // uart_tx stand-in: busy rises the cycle after tx_start and stays high busy_len cycles
   always @(posedge clk) begin
      if (tx_start && busy_en) begin
         busy_q <= 1'b1;
         bcnt <= busy_len;
      end else if (busy_q) begin
         if (bcnt <= 1) busy_q <= 1'b0;
         bcnt <= bcnt - 1;
      end
   end
   assign tx_busy = busy_q | force_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic g);
      exp_t e;
      e.data = d;
      e.gid = g;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (tx_start) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected tx_start got data=%h gid=%0d expected none", tx_data, grant_id);
         end else begin
            e = exp_q.pop_front();
            if (tx_data !== e.data || grant_id !== e.gid) begin
               errors++;
               $display("FAIL sb_byte got data=%h gid=%0d expected data=%h gid=%0d", tx_data, grant_id, e.data, e.gid);
            end
         end
      end
   endtask

   // sel: 0 ready, 1 tx_start, 2 idle, 3 timeout_err, 4 busy low, 5 busy high
   task automatic wait_until(input int sel, input int bound, output int n);
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < bound) begin
         tick();
         n++;
         hit = sel == 0 ? |req_ready : sel == 1 ? tx_start : sel == 2 ? !active :
               sel == 3 ? timeout_err : sel == 4 ? !tx_busy : tx_busy;
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL wait%0d got timeout after %0d cycles expected event", sel, n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n, bad, hi, i0, n1, n1max;
      logic [7:0] pkt[3];
      vecs[0]  = '{1'b1, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 2'b01, 8'h55, 2'b01, 1'b0, 1'b1, 8'h55};
      vecs[2]  = '{1'b0, 2'b00, 8'h55, 2'b00, 1'b0, 1'b1, 8'h55};
      vecs[3]  = '{1'b0, 2'b00, 8'h55, 2'b00, 1'b1, 1'b1, 8'h55};
      vecs[4]  = '{1'b0, 2'b00, 8'h55, 2'b00, 1'b0, 1'b1, 8'h55};
      vecs[5]  = '{1'b0, 2'b00, 8'h55, 2'b00, 1'b0, 1'b1, 8'h55};
      vecs[6]  = '{1'b0, 2'b00, 8'h55, 2'b00, 1'b0, 1'b1, 8'h55};
      vecs[7]  = '{1'b0, 2'b00, 8'h55, 2'b00, 1'b0, 1'b1, 8'h55};
      vecs[8]  = '{1'b0, 2'b00, 8'h55, 2'b00, 1'b0, 1'b0, 8'h55};
      vecs[9]  = '{1'b0, 2'b01, 8'h66, 2'b01, 1'b0, 1'b1, 8'h66};
      vecs[10] = '{1'b0, 2'b00, 8'h66, 2'b00, 1'b0, 1'b1, 8'h66};
      push(8'h55, 1'b0);
      push(8'h66, 1'b0);
      tick();
      for (int i = 0; i < 11; i++) begin
         rst = vecs[i].r;
         req_valid = vecs[i].v;
         req_data[7:0] = vecs[i].d;
         tick();
         check($sformatf("vec%0d", i), {req_ready, tx_start, active, tx_data},
               {vecs[i].rdy, vecs[i].st, vecs[i].act, vecs[i].td});
         if (i == 0) check("reset_gid_err", {grant_id, timeout_err}, 0);
      end
      wait_until(2, 100, n);

      // single requester with a full-length frame
      busy_len = 2340;
      do_reset();
      push(8'h55, 1'b0);
      req_valid = 2'b01;
      req_data[7:0] = 8'h55;
      wait_until(0, 10, n);
      check("t1_ready", {req_ready, grant_id}, {2'b01, 1'b0});
      req_valid = 2'b00;
      tick();
      check("t1_ready_pulse", req_ready, 0);
      tick();
      check("t1_start_lat", tx_start, 1);
      bad = 0;
      hi = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (tx_data !== 8'h55) bad++;
         if (tx_busy) hi++;
         else if (hi > 0) break;
      end
      check("t1_hold", bad, 0);
      check("t1_busy_len", hi, 2340);
      wait_until(2, 10, n);

      // round-robin with both valid
      busy_len = 10;
      do_reset();
      push(8'hA0, 1'b0);
      push(8'hB1, 1'b1);
      push(8'hA0, 1'b0);
      push(8'hB1, 1'b1);
      req_valid = 2'b11;
      req_data = {8'hB1, 8'hA0};
      n1 = 0;
      for (int c = 0; c < 500 && n1 < 4; c++) begin
         tick();
         if (|req_ready) n1++;
      end
      req_valid = 2'b00;
      check("t2_grants", n1, 4);
      wait_until(2, 100, n);

      // timeout with busy never rising
      busy_en = 1'b0;
      do_reset();
      push(8'h77, 1'b0);
      req_valid = 2'b01;
      req_data[7:0] = 8'h77;
      wait_until(0, 10, n);
      req_valid = 2'b00;
      wait_until(1, 10, n);
      check("t3_start_lat", n, 2);
      wait_until(3, 40, n);
      check("t3_timeout_cycles", n, 16);
      check("t3_idle", active, 0);
      push(8'h78, 1'b0);
      req_valid = 2'b01;
      req_data[7:0] = 8'h78;
      wait_until(0, 10, n);
      check("t3_reaccept", {req_ready, tx_data}, {2'b01, 8'h78});
      req_valid = 2'b00;
      wait_until(1, 10, n);
      wait_until(2, 40, n);
      check("t3_second_timeout", n, 16);
      check("t3_sticky", timeout_err, 1);
      busy_en = 1'b1;

      // reset in WAIT_LO while busy stays high
      busy_len = 40;
      do_reset();
      push(8'h11, 1'b0);
      req_valid = 2'b01;
      req_data[7:0] = 8'h11;
      wait_until(0, 10, n);
      req_valid = 2'b00;
      wait_until(5, 10, n);
      tick();
      check("t4_in_flight", {active, tx_busy}, 2'b11);
      force_busy = 1'b1;
      req_valid = 2'b11;
      req_data = {8'h33, 8'h22};
      rst = 1'b1;
      tick();
      check("t4_reset_outs", {req_ready, tx_start, tx_data, grant_id, active, timeout_err}, 0);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (|req_ready || tx_start) bad++;
      end
      check("t4_no_grant_busy", bad, 0);
      push(8'h22, 1'b0);
      force_busy = 1'b0;
      wait_until(0, 5, n);
      check("t4_grant_lat", n, 1);
      check("t4_grant_req0", {req_ready, grant_id}, {2'b01, 1'b0});
      req_valid = 2'b00;
      wait_until(2, 200, n);

      // busy already high at idle
      busy_len = 10;
      do_reset();
      force_busy = 1'b1;
      req_valid = 2'b01;
      req_data[7:0] = 8'h44;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (|req_ready || tx_start) bad++;
      end
      check("t5_blocked", bad, 0);
      push(8'h44, 1'b0);
      force_busy = 1'b0;
      wait_until(0, 5, n);
      check("t5_grant_lat", n, 1);
      req_valid = 2'b00;
      wait_until(2, 200, n);

      // 3-byte packet from requester 0 against a steady requester 1
      do_reset();
      pkt[0] = 8'hC0;
      pkt[1] = 8'hC1;
      pkt[2] = 8'hC2;
`ifdef UART_ARB_LOCK_EN
      n1max = 1;
      push(8'hC0, 1'b0);
      push(8'hC1, 1'b0);
      push(8'hC2, 1'b0);
      push(8'hB1, 1'b1);
`else
      n1max = 2;
      push(8'hC0, 1'b0);
      push(8'hB1, 1'b1);
      push(8'hC1, 1'b0);
      push(8'hB1, 1'b1);
      push(8'hC2, 1'b0);
`endif
      i0 = 0;
      n1 = 0;
      req_data = {8'hB1, pkt[0]};
      req_last = 2'b00;
      req_valid = 2'b11;
      for (int c = 0; c < 2000 && req_valid != 0; c++) begin
         tick();
         if (req_ready[0]) begin
            i0++;
            if (i0 == 3) req_valid[0] = 1'b0;
            else begin
               req_data[7:0] = pkt[i0];
               req_last[0] = i0 == 2;
            end
         end
         if (req_ready[1]) begin
            n1++;
            if (n1 == n1max) req_valid[1] = 1'b0;
         end
      end
      check("t6_done", req_valid, 0);
      req_last = 2'b00;
      wait_until(2, 200, n);
      tick();
      check("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
